// File: rtl/unibus_pkg.sv
// Shared definitions for the Unibus NPR master: cycle-type codes, FSM state codes
// and the post-cycle address step.
package unibus_pkg;

  localparam logic [1:0] C_DATI  = 2'b00;
  localparam logic [1:0] C_DATIP = 2'b01;
  localparam logic [1:0] C_DATO  = 2'b10;
  localparam logic [1:0] C_DATOB = 2'b11;

  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_REQ    = 4'd1;
  localparam logic [3:0] ST_GRANT  = 4'd2;
  localparam logic [3:0] ST_DESKEW = 4'd3;
  localparam logic [3:0] ST_MSYN   = 4'd4;
  localparam logic [3:0] ST_UNSYNC = 4'd5;

  localparam logic [31:0] DMA_ID = 32'h444D_1001;

  // Byte cycles advance one byte, word cycles one word; 18-bit wrap is implicit.
  function automatic logic [17:0] addr_step(input logic [1:0] c);
    return (c == C_DATOB) ? 18'd1 : 18'd2;
  endfunction

endpackage

// File: rtl/unibus_dma.sv
// Unibus NPR bus master: arbitrates for the bus and runs one DATI/DATO/DATOB cycle.
// Optional build macro DMA_AUTOINC_EN advances the address after each successful cycle.
module unibus_dma
  import unibus_pkg::*;
#(
  parameter int DESKEW  = 15,
  parameter int TIMEOUT = 1000
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        armwrite,
  input  logic [1:0]  armraddr,
  input  logic [1:0]  armwaddr,
  input  logic [31:0] armwdata,
  output logic [31:0] armrdata,
  input  logic        init_in_h,
  input  logic        npg_in_h,
  input  logic        bbsy_in_h,
  input  logic        ssyn_in_h,
  input  logic [15:0] d_in_h,
  output logic        npr_out_h,
  output logic        sack_out_h,
  output logic        bbsy_out_h,
  output logic        msyn_out_h,
  output logic [17:0] a_out_h,
  output logic [1:0]  c_out_h,
  output logic [15:0] d_out_h
);

  localparam logic [27:0] DSK_LAST = 28'(DESKEW - 1);
  localparam logic [27:0] TMO      = 28'(TIMEOUT);

  logic [3:0]  state_q, state_d;
  logic [27:0] timer_q, timer_d;
  logic [17:0] addr_q, addr_d;
  logic [1:0]  c_q, c_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic        nxm_q, nxm_d;

  logic busy, own_bus, reg1_wr, reg2_wr;
  logic unused_wbits;

  assign unused_wbits = ^armwdata[30:20];

  assign busy    = (state_q != ST_IDLE);
  assign own_bus = (state_q == ST_DESKEW) || (state_q == ST_MSYN) || (state_q == ST_UNSYNC);
  // Bus-visible registers are frozen while a cycle is in flight.
  assign reg1_wr = armwrite && (armwaddr == 2'd1) && !busy;
  assign reg2_wr = armwrite && (armwaddr == 2'd2) && !busy;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    addr_d  = addr_q;
    c_d     = c_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    nxm_d   = nxm_q;

    if (reg1_wr) begin
      addr_d = armwdata[17:0];
      c_d    = armwdata[19:18];
      nxm_d  = 1'b0;
    end
    if (reg2_wr) wdata_d = armwdata[15:0];

    if (init_in_h) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   if (reg1_wr && armwdata[31]) state_d = ST_REQ;
        ST_REQ:    if (npg_in_h) state_d = ST_GRANT;
        ST_GRANT: begin
          if (!npg_in_h && !bbsy_in_h && !ssyn_in_h) begin
            state_d = ST_DESKEW;
            timer_d = '0;
          end
        end
        ST_DESKEW: begin
          if (timer_q == DSK_LAST) begin
            state_d = ST_MSYN;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 28'd1;
          end
        end
        ST_MSYN: begin
          if (ssyn_in_h) begin
            if (!c_q[1]) rdata_d = d_in_h;
`ifdef DMA_AUTOINC_EN
            addr_d = addr_q + addr_step(c_q);
`endif
            state_d = ST_UNSYNC;
          end else if (timer_q == TMO) begin
            nxm_d   = 1'b1;
            state_d = ST_UNSYNC;
          end else begin
            timer_d = timer_q + 28'd1;
          end
        end
        ST_UNSYNC: if (!ssyn_in_h) state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      addr_q  <= '0;
      c_q     <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      nxm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      addr_q  <= addr_d;
      c_q     <= c_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      nxm_q   <= nxm_d;
    end
  end

  // Byte-lane choice for DATOB is made by the slave from a_out_h[0].
  assign npr_out_h  = (state_q == ST_REQ);
  assign sack_out_h = (state_q == ST_GRANT);
  assign bbsy_out_h = own_bus;
  assign msyn_out_h = (state_q == ST_MSYN);
  assign a_out_h    = own_bus ? addr_q : 18'd0;
  assign c_out_h    = own_bus ? c_q : 2'd0;
  assign d_out_h    = (own_bus && c_q[1]) ? wdata_q : 16'd0;

  always_comb begin
    case (armraddr)
      2'd0:    armrdata = DMA_ID;
      2'd1:    armrdata = {busy, nxm_q, 10'b0, c_q, addr_q};
      2'd2:    armrdata = {rdata_q, wdata_q};
      default: armrdata = {state_q, timer_q};
    endcase
  end

endmodule

// File: tb/tb_unibus_dma.sv
// Scoreboard bench for unibus_dma: directed cycles against a small slave/arbiter model.
module tb_unibus_dma;

  localparam int DESKEW  = 15;
  localparam int TIMEOUT = 100;

  logic        CLOCK, RESET;
  logic        armwrite;
  logic [1:0]  armraddr, armwaddr;
  logic [31:0] armwdata, armrdata;
  logic        init_in_h, npg_in_h, bbsy_in_h, ssyn_in_h;
  logic [15:0] d_in_h;
  logic        npr_out_h, sack_out_h, bbsy_out_h, msyn_out_h;
  logic [17:0] a_out_h;
  logic [1:0]  c_out_h;
  logic [15:0] d_out_h;

  unibus_dma #(.DESKEW(DESKEW), .TIMEOUT(TIMEOUT)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .armwrite(armwrite), .armraddr(armraddr),
    .armwaddr(armwaddr), .armwdata(armwdata), .armrdata(armrdata),
    .init_in_h(init_in_h), .npg_in_h(npg_in_h), .bbsy_in_h(bbsy_in_h),
    .ssyn_in_h(ssyn_in_h), .d_in_h(d_in_h), .npr_out_h(npr_out_h),
    .sack_out_h(sack_out_h), .bbsy_out_h(bbsy_out_h), .msyn_out_h(msyn_out_h),
    .a_out_h(a_out_h), .c_out_h(c_out_h), .d_out_h(d_out_h)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  typedef struct {
    string       name;
    logic [31:0] reg1;
    logic [31:0] mask;
    int          rd;     // expected rdata, -1 = skip
    int          gap;    // bbsy->msyn clocks, -1 = skip
    int          dout;   // d_out_h while bus owned, -1 = skip
    int          sack;   // sack high clocks, -1 = skip
    int          mlen;   // msyn high clocks, -1 = skip
    int          abort;  // 1 = busy must drop one clock after init
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0, n_fail = 0;
  int   cyc = 0, init_cyc = 0;
  bit   rst_done = 0, snap_req = 0;
  bit   slave_en = 0;
  logic [15:0] slave_data = 16'h0;

  int t_bbsy = 0, gap = -1, mlen = 0, slen = 0, dout_seen = -1;
  bit overlap = 0;
  logic pbbsy = 0, pmsyn = 0, pnpr = 0;

  always @(posedge CLOCK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk1(input logic busy, input logic nxm,
                                      input logic [1:0] c, input logic [17:0] a);
    return {busy, nxm, 10'b0, c, a};
  endfunction

  function automatic logic [17:0] next_addr(input logic [17:0] a, input logic [1:0] c);
`ifdef DMA_AUTOINC_EN
    return a + ((c == 2'b11) ? 18'd1 : 18'd2);
`else
    return a;
`endif
  endfunction

  // Bus watcher: per-transaction timing and data observations.
  always @(negedge CLOCK) begin
    if (npr_out_h && !pnpr) begin
      overlap = 0; slen = 0; mlen = 0; gap = -1; dout_seen = -1;
    end
    if (bbsy_out_h && !pbbsy) t_bbsy = cyc;
    if (msyn_out_h && !pmsyn) gap = cyc - t_bbsy;
    if (msyn_out_h) mlen++;
    if (sack_out_h) slen++;
    if (bbsy_out_h) dout_seen = int'(d_out_h);
    if (bbsy_out_h && bbsy_in_h) overlap = 1;
    pbbsy = bbsy_out_h; pmsyn = msyn_out_h; pnpr = npr_out_h;
  end

  // Slave model: answers MSYN one clock later, releases SSYN after MSYN drops.
  initial begin
    ssyn_in_h = 1'b0;
    d_in_h    = 16'h0;
    forever begin
      @(negedge CLOCK);
      if (msyn_out_h && slave_en && !ssyn_in_h) begin
        @(posedge CLOCK); #1;
        ssyn_in_h = 1'b1;
        d_in_h    = slave_data;
        for (int k = 0; k < 1000 && msyn_out_h; k++) @(negedge CLOCK);
        @(posedge CLOCK); #1;
        ssyn_in_h = 1'b0;
        d_in_h    = 16'h0;
      end
    end
  end

  // Monitor: reset checks, then pops an expectation whenever busy falls or a snapshot is requested.
  initial begin
    logic [31:0] rd1, rd2;
    logic        pbusy;
    exp_t        e;
    pbusy    = 1'b0;
    armraddr = 2'd1;
    wait (rst_done);
    @(negedge CLOCK);
    armraddr = 2'd0; #1; check("rst.reg0", armrdata, 32'h444D1001);
    armraddr = 2'd1; #1; check("rst.reg1", armrdata, 32'h0);
    armraddr = 2'd2; #1; check("rst.reg2", armrdata, 32'h0);
    armraddr = 2'd3; #1; check("rst.reg3", armrdata, 32'h0);
    armraddr = 2'd1; #1;
    check("rst.bus", {npr_out_h, sack_out_h, bbsy_out_h, msyn_out_h, a_out_h, c_out_h, d_out_h}, 32'h0);
    forever begin
      @(negedge CLOCK);
      rd1 = armrdata;
      if ((pbusy && !rd1[31]) || snap_req) begin
        if (sb.size() == 0) begin
          check("sb.unexpected", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check({e.name, ".reg1"}, rd1 & e.mask, e.reg1 & e.mask);
          if (e.rd >= 0) begin
            armraddr = 2'd2; #1;
            rd2 = armrdata;
            armraddr = 2'd1;
            check({e.name, ".rdata"}, {16'h0, rd2[31:16]}, e.rd);
          end
          if (!snap_req) begin
            check({e.name, ".bus_idle"},
                  {npr_out_h, sack_out_h, bbsy_out_h, msyn_out_h, a_out_h, c_out_h, d_out_h}, 32'h0);
            check({e.name, ".no_overlap"}, {31'b0, overlap}, 32'h0);
          end
          if (e.gap  >= 0) check({e.name, ".deskew"}, gap, e.gap);
          if (e.dout >= 0) check({e.name, ".dout"}, dout_seen, e.dout);
          if (e.sack >= 0) check({e.name, ".sack_len"}, slen, e.sack);
          if (e.mlen >= 0) check({e.name, ".msyn_len"}, mlen, e.mlen);
          if (e.abort == 1) check({e.name, ".abort_lat"}, cyc - init_cyc, 32'd1);
        end
      end
      pbusy = rd1[31];
    end
  end

  task automatic clk1();
    @(posedge CLOCK); #1;
  endtask

  task automatic arm_wr(input logic [1:0] a, input logic [31:0] d);
    armwrite = 1'b1; armwaddr = a; armwdata = d;
    clk1();
    armwrite = 1'b0;
  endtask

  task automatic wait_level(input string name, input int sel, input logic lvl, input int budget);
    int n;
    logic s;
    n = 0;
    s = ~lvl;
    while (n < budget) begin
      case (sel)
        0: s = npr_out_h;
        1: s = sack_out_h;
        2: s = bbsy_out_h;
        default: s = msyn_out_h;
      endcase
      if (s == lvl) break;
      clk1();
      n++;
    end
    if (s != lvl) check({"timeout.", name}, {31'b0, s}, {31'b0, lvl});
  endtask

  task automatic grant();
    wait_level("npr", 0, 1'b1, 20);
    npg_in_h = 1'b1;
    clk1();
    wait_level("sack", 1, 1'b1, 20);
    npg_in_h = 1'b0;
  endtask

  task automatic finish_cycle();
    wait_level("bbsy_up", 2, 1'b1, 200);
    wait_level("bbsy_dn", 2, 1'b0, TIMEOUT + 200);
    repeat (3) clk1();
  endtask

  task automatic push(input string n, input logic [31:0] r1, input logic [31:0] m, input int rd,
                      input int g, input int dv, input int sk, input int ml, input int ab);
    exp_t e;
    e.name = n; e.reg1 = r1; e.mask = m; e.rd = rd; e.gap = g;
    e.dout = dv; e.sack = sk; e.mlen = ml; e.abort = ab;
    sb.push_back(e);
  endtask

  task automatic snap();
    snap_req = 1'b1;
    clk1();
    snap_req = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1; armwrite = 1'b0; armwaddr = 2'd0; armwdata = 32'h0;
    init_in_h = 1'b0; npg_in_h = 1'b0; bbsy_in_h = 1'b0;
    repeat (3) clk1();
    RESET = 1'b0;
    rst_done = 1'b1;
    repeat (3) clk1();

    // DATI at 017776, slave returns 0123456.
    slave_en = 1'b1; slave_data = 16'o123456;
    push("t1_dati", mk1(0, 0, 2'b00, next_addr(18'o017776, 2'b00)), 32'hFFFF_FFFF,
         'o123456, DESKEW, 0, -1, 2, 0);
    arm_wr(2'd1, {1'b1, 11'b0, 2'b00, 18'o017776});
    grant(); finish_cycle();

    // DATO of 052525 at 001000; rdata keeps the previous read.
    push("t2_dato", mk1(0, 0, 2'b10, next_addr(18'o001000, 2'b10)), 32'hFFFF_FFFF,
         'o123456, DESKEW, 'o052525, -1, 2, 0);
    arm_wr(2'd2, 32'o052525);
    arm_wr(2'd1, {1'b1, 11'b0, 2'b10, 18'o001000});
    grant(); finish_cycle();

    // No slave: NXM after the timeout, address and rdata untouched.
    slave_en = 1'b0;
    push("t3_nxm", mk1(0, 1, 2'b00, 18'o000100), 32'hFFFF_FFFF,
         'o123456, DESKEW, 0, -1, TIMEOUT + 1, 0);
    arm_wr(2'd1, {1'b1, 11'b0, 2'b00, 18'o000100});
    grant(); finish_cycle();
    push("t3_clear", mk1(0, 0, 2'b00, 18'o000100), 32'hFFFF_FFFF, -1, -1, -1, -1, -1, 0);
    arm_wr(2'd1, {1'b0, 11'b0, 2'b00, 18'o000100});
    snap();

    // Another master holds BBSY for 50 clocks after grant; a start while busy is ignored.
    slave_en = 1'b1;
    push("t4_bbsy", mk1(0, 0, 2'b10, next_addr(18'o002000, 2'b10)), 32'hFFFF_FFFF,
         'o123456, DESKEW, 'h1234, 50, 2, 0);
    arm_wr(2'd2, 32'h0000_1234);
    arm_wr(2'd1, {1'b1, 11'b0, 2'b10, 18'o002000});
    wait_level("npr4", 0, 1'b1, 20);
    npg_in_h = 1'b1; bbsy_in_h = 1'b1;
    for (int i = 0; i < 50; i++) begin
      clk1();
      if (i == 1) npg_in_h = 1'b0;
      if (i == 10) begin
        armwrite = 1'b1; armwaddr = 2'd1; armwdata = {1'b1, 11'b0, 2'b00, 18'o003000};
      end
      if (i == 11) armwrite = 1'b0;
    end
    bbsy_in_h = 1'b0;
    finish_cycle();

    // INIT pulsed during MSYN aborts the cycle without NXM.
    slave_en = 1'b0;
    push("t5_init", mk1(0, 0, 2'b00, 18'o000200), 32'hFFFF_FFFF,
         'o123456, DESKEW, 0, -1, -1, 1);
    arm_wr(2'd1, {1'b1, 11'b0, 2'b00, 18'o000200});
    grant();
    wait_level("msyn5", 3, 1'b1, 100);
    repeat (5) clk1();
    init_in_h = 1'b1; init_cyc = cyc;
    clk1();
    init_in_h = 1'b0;
    repeat (3) clk1();

    // INIT together with start: start loses.
    push("t5_init_start", 32'h0, 32'hC000_0000, -1, -1, -1, -1, -1, 0);
    armwrite = 1'b1; armwaddr = 2'd1; armwdata = {1'b1, 11'b0, 2'b00, 18'o000300};
    init_in_h = 1'b1;
    clk1();
    armwrite = 1'b0; init_in_h = 1'b0;
    snap();
    repeat (5) clk1();
    check("t5_no_request", {31'b0, npr_out_h}, 32'h0);

    // Address wrap at top of memory and byte-cycle step.
    slave_en = 1'b1;
    push("t6_wrap", mk1(0, 0, 2'b10, next_addr(18'o777776, 2'b10)), 32'hFFFF_FFFF,
         'o123456, DESKEW, 'h1234, -1, 2, 0);
    arm_wr(2'd1, {1'b1, 11'b0, 2'b10, 18'o777776});
    grant(); finish_cycle();
    push("t6_datob", mk1(0, 0, 2'b11, next_addr(18'o001001, 2'b11)), 32'hFFFF_FFFF,
         'o123456, DESKEW, 'h1234, -1, 2, 0);
    arm_wr(2'd1, {1'b1, 11'b0, 2'b11, 18'o001001});
    grant(); finish_cycle();

    repeat (3) clk1();
    check("sb.drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
